button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: number of consecutive stable cycles required to accept a level change (1 ms at 50 MHz).
REQ-002 Parameter CNT_W, default 16: debounce counter width.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-low reset; sampled on rising clk only.
REQ-005 Port bc_raw  input  1: raw clockwise push-button, asynchronous to clk, bouncing.
REQ-006 Port bac_raw  input  1: raw anticlockwise push-button, asynchronous to clk, bouncing.
REQ-007 Port bc_pulse  output  1: one-cycle pulse per accepted clockwise press; drives the button register's bc input.
REQ-008 Port bac_pulse  output  1: one-cycle pulse per accepted anticlockwise press; drives the button register's bac input.
REQ-009 Port bc_level  output  1: debounced clockwise level.
REQ-010 Port bac_level  output  1: debounced anticlockwise level.
REQ-011 Port conflict  output  1: one-cycle pulse when both presses are accepted in the same cycle.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer; only the second flop output (sync) feeds logic.
REQ-013 Each channel SHALL run an independent FSM with states IDLE, RISE_WAIT, HELD, FALL_WAIT.
REQ-014 IDLE: sync=1 -> RISE_WAIT with counter cleared to 0; otherwise remain in IDLE.
REQ-015 RISE_WAIT: sync=0 -> IDLE (glitch rejected, no pulse); sync=1 and counter<DEBOUNCE_CYCLES-1 -> increment; sync=1 and counter=DEBOUNCE_CYCLES-1 -> HELD.
REQ-016 HELD: sync=0 -> FALL_WAIT with counter cleared; otherwise remain in HELD; no further pulses (no auto-repeat).
REQ-017 FALL_WAIT: sync=1 -> HELD (no pulse); sync=0 and counter=DEBOUNCE_CYCLES-1 -> IDLE; otherwise increment.
REQ-018 The level output SHALL be 1 in HELD and FALL_WAIT and 0 in IDLE and RISE_WAIT, registered.
REQ-019 The pulse output SHALL be registered and high for exactly the first cycle in HELD entered from RISE_WAIT.
REQ-020 Latency: with raw held stable high, the pulse SHALL be high in the cycle following clock edge DEBOUNCE_CYCLES+3, counting the first edge that samples raw high as edge 1.
REQ-021 The counter SHALL never wrap; it is cleared on every state entry and held at DEBOUNCE_CYCLES-1 at most.
REQ-022 If both channels enter HELD from RISE_WAIT in the same cycle, bc_pulse and bac_pulse SHALL both stay 0 and conflict SHALL pulse for one cycle; both levels still go to 1.
REQ-023 Pulses accepted in different cycles SHALL pass through independently, even while the other channel is HELD.
REQ-024 DEBOUNCE_CYCLES SHALL be >=2 and <=2**CNT_W; violation is an elaboration error.

Reset
REQ-025 While reset=0 at a clk edge: synchronizer flops clear to 0, FSMs go to IDLE, counters clear to 0, and all outputs go to 0.
REQ-026 Reset asserted mid-debounce or in HELD SHALL abort with no pulse.
REQ-027 If a raw input is high when reset releases, a full debounce SHALL be run and exactly one pulse emitted.

Structure
REQ-028 Package button_pkg SHALL hold the FSM state typedef (2-bit encoding) and the default DEBOUNCE_CYCLES and CNT_W constants.
REQ-029 Sub-module debounce_channel (synchronizer, counter, FSM, level, raw-accept strobe) SHALL be instantiated twice.
REQ-030 The top level SHALL contain only the conflict arbitration and the output pulse registers.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Clean press: bc_raw held 1 from edge 1 -> bc_pulse=1 only in the cycle after edge 7, bc_level=1 from then on, and bac_pulse stays 0.
REQ-032 Bounce: bc_raw toggles 1,0,1,0 on alternate cycles, then holds 1 -> no pulse during the toggling, and exactly one pulse 7 edges after the final rise.
REQ-033 Hold then release: bac_raw held 1 for 40 cycles, then 0 for 10 cycles -> one bac_pulse, and bac_level returns to 0 seven edges after the fall.
REQ-034 Simultaneous press: bc_raw and bac_raw rise on the same edge -> conflict pulses once, both pulses stay 0, and both levels go to 1.
REQ-035 Reset abort: bc_raw rises, reset=0 at edge 4 for 2 cycles, bc_raw still 1 -> no pulse before reset release, then one pulse 7 edges after release.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// Shared types and defaults for the two-button debouncer.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RISE_WAIT = 2'b01,
    HELD      = 2'b10,
    FALL_WAIT = 2'b11
  } btn_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;
  localparam int unsigned CNT_W_DEF           = 16;

endpackage

// File: rtl/button_debounce_if.sv
// Per-button channel bundle: raw input in, debounced level and accept strobe out.
interface button_debounce_if;

  logic raw;
  logic level;
  logic accept;

  modport channel (input raw, output level, output accept);
  modport ctrl    (output raw, input level, input accept);

endinterface

// File: rtl/button_debounce_channel.sv
// One debounce channel: 2-flop synchronizer, stability counter, FSM and level register.
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  button_debounce_if.channel ch
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync_q;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             accept_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= ch.raw;
      sync_q  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // accept_d marks the RISE_WAIT->HELD transition; the top registers it into the pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_q) begin
          state_d = RISE_WAIT;
          cnt_d   = '0;
        end
      end
      RISE_WAIT: begin
        if (!sync_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d  = HELD;
          cnt_d    = '0;
          accept_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!sync_q) begin
          state_d = FALL_WAIT;
          cnt_d   = '0;
        end
      end
      FALL_WAIT: begin
        if (sync_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == HELD) || (state_d == FALL_WAIT);
  end

  assign ch.level  = level_q;
  assign ch.accept = accept_d;

endmodule

// File: rtl/button_debounce.sv
// Two debounced push-buttons with registered press pulses; simultaneous presses raise conflict instead.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic bc_raw,
  input  logic bac_raw,
  output logic bc_pulse,
  output logic bac_pulse,
  output logic bc_level,
  output logic bac_level,
  output logic conflict
);

  if ((DEBOUNCE_CYCLES < 2) || (64'(DEBOUNCE_CYCLES) > (64'd1 << CNT_W))) begin : g_param_check
    $fatal(1, "button_debounce: DEBOUNCE_CYCLES must lie in [2, 2**CNT_W]");
  end

  button_debounce_if bc_ch ();
  button_debounce_if bac_ch ();

  assign bc_ch.raw  = bc_raw;
  assign bac_ch.raw = bac_raw;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_bc (
    .clk  (clk),
    .reset(reset),
    .ch   (bc_ch)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_bac (
    .clk  (clk),
    .reset(reset),
    .ch   (bac_ch)
  );

  logic bc_pulse_q, bac_pulse_q, conflict_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      bc_pulse_q  <= 1'b0;
      bac_pulse_q <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      bc_pulse_q  <= bc_ch.accept & ~bac_ch.accept;
      bac_pulse_q <= bac_ch.accept & ~bc_ch.accept;
      conflict_q  <= bc_ch.accept & bac_ch.accept;
    end
  end

  assign bc_pulse  = bc_pulse_q;
  assign bac_pulse = bac_pulse_q;
  assign conflict  = conflict_q;
  assign bc_level  = bc_ch.level;
  assign bac_level = bac_ch.level;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce with DEBOUNCE_CYCLES=4 and a run-length reference model.
module tb_button_debounce;

  localparam int unsigned D = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic bc_pulse, bac_pulse, conflict;

  button_debounce_if bc_if ();
  button_debounce_if bac_if ();

  assign bc_if.accept  = 1'b0;
  assign bac_if.accept = 1'b0;

  button_debounce #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bc_raw   (bc_if.raw),
    .bac_raw  (bac_if.raw),
    .bc_pulse (bc_pulse),
    .bac_pulse(bac_pulse),
    .bc_level (bc_if.level),
    .bac_level(bac_if.level),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: a level flips once the input seen two edges late has differed
  // from it for D+1 consecutive samples; a 0->1 flip is an accepted press.
  logic        m_d1    [2];
  logic        m_d2    [2];
  logic        m_level [2];
  logic        m_acc   [2];
  logic        m_raw   [2];
  int unsigned m_run   [2];
  logic [4:0]  m_exp;

  always @(posedge clk) begin
    m_raw[0] = bc_if.raw;
    m_raw[1] = bac_if.raw;
    if (!reset) begin
      for (int c = 0; c < 2; c++) begin
        m_d1[c] = 1'b0; m_d2[c] = 1'b0; m_level[c] = 1'b0; m_run[c] = 0; m_acc[c] = 1'b0;
      end
      m_exp = '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_acc[c] = 1'b0;
        if (m_d2[c] != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == D + 1) begin
            m_level[c] = m_d2[c];
            m_run[c]   = 0;
            m_acc[c]   = m_level[c];
          end
        end else begin
          m_run[c] = 0;
        end
        m_d2[c] = m_d1[c];
        m_d1[c] = m_raw[c];
      end
      m_exp = {m_acc[0] & ~m_acc[1], m_acc[1] & ~m_acc[0], m_acc[0] & m_acc[1],
               m_level[0], m_level[1]};
    end
  end

  function automatic logic [4:0] obs();
    return {bc_pulse, bac_pulse, conflict, bc_if.level, bac_if.level};
  endfunction

  task automatic tick(input logic bc, input logic bac, input logic rst_n);
    bc_if.raw  = bc;
    bac_if.raw = bac;
    reset      = rst_n;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 1; i <= 4; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      n_checks++;
      if (obs() !== 5'b0) begin
        n_fail++;
        $display("FAIL reset cyc%0d: got %b want 00000", i, obs());
      end
    end
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (obs() !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: got %b want 00000", i, obs());
      end
    end
  endtask

  task automatic test_clean_press();
    logic [4:0] exp;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1, 1'b0, 1'b1);
      exp = {1'(i == 7), 1'b0, 1'b0, 1'(i >= 7), 1'b0};
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL clean_press cyc%0d: got %b want %b", i, obs(), exp);
      end
    end
    for (int i = 1; i <= 10; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      exp = {1'b0, 1'b0, 1'b0, 1'(i < 7), 1'b0};
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL clean_release cyc%0d: got %b want %b", i, obs(), exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] exp;
    for (int i = 1; i <= 16; i++) begin
      tick((i <= 4) ? 1'(i % 2) : 1'b1, 1'b0, 1'b1);
      exp = {1'(i == 11), 1'b0, 1'b0, 1'(i >= 11), 1'b0};
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL bounce cyc%0d: got %b want %b", i, obs(), exp);
      end
    end
    repeat (10) tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_hold_release();
    logic [4:0] exp;
    for (int i = 1; i <= 50; i++) begin
      tick(1'b0, 1'(i <= 40), 1'b1);
      if (i <= 40) exp = {1'b0, 1'(i == 7), 1'b0, 1'b0, 1'(i >= 7)};
      else         exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'(i - 40 < 7)};
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL hold_release cyc%0d: got %b want %b", i, obs(), exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] exp;
    for (int i = 1; i <= 22; i++) begin
      tick(1'(i <= 12), 1'(i <= 12), 1'b1);
      if (i <= 12) exp = {1'b0, 1'b0, 1'(i == 7), 1'(i >= 7), 1'(i >= 7)};
      else         exp = {1'b0, 1'b0, 1'b0, 1'(i - 12 < 7), 1'(i - 12 < 7)};
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL simultaneous cyc%0d: got %b want %b", i, obs(), exp);
      end
    end
  endtask

  task automatic test_independent();
    logic [4:0] exp;
    for (int i = 1; i <= 20; i++) begin
      tick(1'(i >= 4), 1'b1, 1'b1);
      exp = {1'(i == 10), 1'(i == 7), 1'b0, 1'(i >= 10), 1'(i >= 7)};
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL independent cyc%0d: got %b want %b", i, obs(), exp);
      end
    end
    repeat (10) tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_abort();
    logic [4:0] exp;
    for (int i = 1; i <= 14; i++) begin
      tick(1'b1, 1'b0, 1'(!(i == 4 || i == 5)));
      exp = {1'(i == 12), 1'b0, 1'b0, 1'(i >= 12), 1'b0};
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL reset_abort cyc%0d: got %b want %b", i, obs(), exp);
      end
    end
    repeat (10) tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_boundary();
    int pulses = 0;
    int len[4] = '{D, 8, D + 1, 12};
    for (int seg = 0; seg < 4; seg++) begin
      for (int i = 0; i < len[seg]; i++) begin
        tick(1'(seg % 2 == 0), 1'b0, 1'b1);
        if (bc_pulse === 1'b1) pulses++;
        n_checks++;
        if (obs() !== m_exp) begin
          n_fail++;
          $display("FAIL boundary seg%0d cyc%0d: got %b want %b", seg, i, obs(), m_exp);
        end
      end
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL boundary_pulse_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_random();
    logic        val [2];
    int unsigned rem [2];
    logic        rst_n;
    for (int c = 0; c < 2; c++) begin val[c] = 1'b0; rem[c] = 0; end
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (rem[c] == 0) begin
          val[c] = ~val[c];
          rem[c] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 15);
        end
        rem[c]--;
      end
      rst_n = ($urandom_range(0, 99) != 0);
      tick(val[0], val[1], rst_n);
      n_checks++;
      if (obs() !== m_exp) begin
        n_fail++;
        $display("FAIL random cyc%0d: got %b want %b", i, obs(), m_exp);
      end
    end
  endtask

  initial begin
    bc_if.raw  = 1'b0;
    bac_if.raw = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_release();
    test_simultaneous();
    test_independent();
    test_reset_abort();
    test_boundary();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
